// File: rtl/vai_tx_c0_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 Tx channel among sub-AFUs.
// Define VAI_TX_ARB_STATS_EN to build the per-requester grant counters.
module vai_tx_c0_arbiter #(
  parameter int NUM_SUB_AFUS = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_WIDTH   = 42
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_SUB_AFUS-1:0]              afu_req_valid,
  input  logic [NUM_SUB_AFUS*ADDR_WIDTH-1:0]   afu_req_addr,
  input  logic [NUM_SUB_AFUS*16-1:0]           afu_req_mdata,
  output logic [NUM_SUB_AFUS-1:0]              afu_almfull,
  input  logic [NUM_SUB_AFUS*64-1:0]           offset_array,
  input  logic                                 up_almfull,
  output logic                                 up_req_valid,
  output logic [ADDR_WIDTH-1:0]                up_req_addr,
  output logic [15:0]                          up_req_mdata,
  input  logic                                 cfg_pause,
  output logic                                 cfg_paused,
  output logic [NUM_SUB_AFUS-1:0]              overflow_err,
  output logic [NUM_SUB_AFUS-1:0]              mdata_err,
  output logic [NUM_SUB_AFUS*32-1:0]           grant_count
);

  localparam int VW = (NUM_SUB_AFUS > 1) ? $clog2(NUM_SUB_AFUS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + 16 - VW;

  typedef logic [VW-1:0] vmid_t;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

  state_t state, state_nxt;
  vmid_t  rr_ptr, winner, cand;
  logic   grant, found;

  // Entries hold {addr, low mdata}; the vmid bits are restamped on issue.
  logic [EW-1:0] mem [NUM_SUB_AFUS][FIFO_DEPTH];
  ptr_t wr_ptr  [NUM_SUB_AFUS];
  ptr_t rd_ptr  [NUM_SUB_AFUS];
  cnt_t count   [NUM_SUB_AFUS];
  cnt_t cnt_nxt [NUM_SUB_AFUS];

  logic [NUM_SUB_AFUS-1:0] nonempty, full, push, pop;
  logic [EW-1:0]           head;
  logic [ADDR_WIDTH-1:0]   off;
  logic                    unused_bits;

  assign unused_bits = ^offset_array;

  always_comb begin
    for (int n = 0; n < NUM_SUB_AFUS; n++) begin
      nonempty[n] = count[n] != '0;
      full[n]     = count[n] == cnt_t'(FIFO_DEPTH);
      push[n]     = afu_req_valid[n] && !full[n];
      pop[n]      = grant && (winner == vmid_t'(n));
      cnt_nxt[n]  = count[n] + cnt_t'(push[n]) - cnt_t'(pop[n]);
    end
  end

  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int i = 1; i <= NUM_SUB_AFUS; i++) begin
      cand = vmid_t'((int'(rr_ptr) + i) % NUM_SUB_AFUS);
      if (!found && nonempty[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign grant = (state == RUN) && !cfg_pause && !up_almfull && found;
  assign head  = mem[winner][rd_ptr[winner]];
  assign off   = offset_array[int'(winner)*64 +: ADDR_WIDTH];

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (cfg_pause)     state_nxt = DRAIN;
      DRAIN:   if (!up_req_valid) state_nxt = PAUSED;
      PAUSED:  if (!cfg_pause)    state_nxt = RUN;
      default:                    state_nxt = RUN;
    endcase
  end

  assign cfg_paused = (state == PAUSED);

  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_SUB_AFUS; n++) begin
      if (push[n]) begin
        mem[n][wr_ptr[n]] <= {afu_req_addr[n*ADDR_WIDTH +: ADDR_WIDTH],
                              afu_req_mdata[n*16 +: 16-VW]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_SUB_AFUS; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
      end
      afu_almfull  <= '0;
      overflow_err <= '0;
      mdata_err    <= '0;
    end else begin
      for (int n = 0; n < NUM_SUB_AFUS; n++) begin
        if (push[n]) wr_ptr[n] <= wr_ptr[n] + ptr_t'(1);
        if (pop[n])  rd_ptr[n] <= rd_ptr[n] + ptr_t'(1);
        count[n]       <= cnt_nxt[n];
        afu_almfull[n] <= cnt_nxt[n] >= cnt_t'(FIFO_DEPTH-2);
        if (afu_req_valid[n] && full[n])
          overflow_err[n] <= 1'b1;
        if (afu_req_valid[n] && afu_req_mdata[n*16+15 -: VW] != '0)
          mdata_err[n] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      rr_ptr       <= vmid_t'(NUM_SUB_AFUS-1);
      up_req_valid <= 1'b0;
      up_req_addr  <= '0;
      up_req_mdata <= '0;
    end else begin
      state        <= state_nxt;
      up_req_valid <= grant;
      if (grant) begin
        rr_ptr       <= winner;
        up_req_addr  <= head[EW-1 -: ADDR_WIDTH] + off;
        up_req_mdata <= {winner, head[15-VW:0]};
      end else begin
        up_req_addr  <= '0;
        up_req_mdata <= '0;
      end
    end
  end

`ifdef VAI_TX_ARB_STATS_EN
  logic [31:0] gcnt [NUM_SUB_AFUS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_SUB_AFUS; n++) gcnt[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_SUB_AFUS; n++)
        if (pop[n]) gcnt[n] <= gcnt[n] + 32'd1;
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_SUB_AFUS; n++)
      grant_count[n*32 +: 32] = gcnt[n];
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_vai_tx_c0_arbiter.sv
// Scoreboard bench for vai_tx_c0_arbiter: ordering, relocation,
// backpressure, overflow, pause handshake and asynchronous reset.
module tb_vai_tx_c0_arbiter;

  localparam int N  = 8;
  localparam int AW = 42;
  localparam int VW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   mdata;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    afu_req_valid = '0;
  logic [N*AW-1:0] afu_req_addr = '0;
  logic [N*16-1:0] afu_req_mdata = '0;
  logic [N-1:0]    afu_almfull;
  logic [N*64-1:0] offset_array = '0;
  logic            up_almfull = 1'b0;
  logic            up_req_valid;
  logic [AW-1:0]   up_req_addr;
  logic [15:0]     up_req_mdata;
  logic            cfg_pause = 1'b0;
  logic            cfg_paused;
  logic [N-1:0]    overflow_err;
  logic [N-1:0]    mdata_err;
  logic [N*32-1:0] grant_count;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   issue_cnt = 0;

  vai_tx_c0_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .afu_req_valid(afu_req_valid),
    .afu_req_addr (afu_req_addr),
    .afu_req_mdata(afu_req_mdata),
    .afu_almfull  (afu_almfull),
    .offset_array (offset_array),
    .up_almfull   (up_almfull),
    .up_req_valid (up_req_valid),
    .up_req_addr  (up_req_addr),
    .up_req_mdata (up_req_mdata),
    .cfg_pause    (cfg_pause),
    .cfg_paused   (cfg_paused),
    .overflow_err (overflow_err),
    .mdata_err    (mdata_err),
    .grant_count  (grant_count)
  );

  initial forever #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && up_req_valid) begin
      issue_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected addr=%h mdata=%h",
                 up_req_addr, up_req_mdata);
      end else begin
        mon_e = sb.pop_front();
        if (up_req_addr !== mon_e.addr ||
            up_req_mdata !== mon_e.mdata) begin
          errors++;
          $display("FAIL sb_data got %h/%h expected %h/%h",
                   up_req_addr, up_req_mdata,
                   mon_e.addr, mon_e.mdata);
        end
      end
    end
  end

  function automatic exp_t model(int n, logic [AW-1:0] a,
                                 logic [15:0] m);
    exp_t e;
    logic [VW-1:0] v;
    v = VW'(n);
    e.addr  = a + offset_array[n*64 +: AW];
    e.mdata = {v, m[15-VW:0]};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int n, logic [AW-1:0] a, logic [15:0] m,
                       bit expect_it);
    afu_req_valid[n] = 1'b1;
    afu_req_addr[n*AW +: AW] = a;
    afu_req_mdata[n*16 +: 16] = m;
    if (expect_it) sb.push_back(model(n, a, m));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    afu_req_valid = '0;
    up_almfull = 1'b0;
    cfg_pause = 1'b0;
    offset_array = '0;
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic check_drained(string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drained pending=%0d expected 0",
               name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({up_req_valid, up_req_addr, up_req_mdata, cfg_paused} !== '0) begin
      errors++;
      $display("FAIL reset_out valid=%b addr=%h mdata=%h paused=%b exp 0",
               up_req_valid, up_req_addr, up_req_mdata, cfg_paused);
    end
    checks++;
    if ({afu_almfull, overflow_err, mdata_err} !== '0) begin
      errors++;
      $display("FAIL reset_flags almfull=%h ovf=%h merr=%h exp 0",
               afu_almfull, overflow_err, mdata_err);
    end
    checks++;
    if (grant_count !== '0) begin
      errors++;
      $display("FAIL reset_gcnt got %h expected 0", grant_count);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    offset_array[2*64 +: 64] = 64'h1000;
    drive(2, 42'h100, 16'h0012, 1'b1);
    tick();
    afu_req_valid = '0;
    checks++;
    if (up_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early valid=%b expected 0", up_req_valid);
    end
    tick();
    checks++;
    if (up_req_valid !== 1'b1 || up_req_addr !== 42'h1100 ||
        up_req_mdata !== 16'h4012) begin
      errors++;
      $display("FAIL single_issue got %b %h %h expected 1 1100 4012",
               up_req_valid, up_req_addr, up_req_mdata);
    end
    tick();
    checks++;
    if ({up_req_valid, up_req_addr, up_req_mdata} !== '0) begin
      errors++;
      $display("FAIL single_after got %b %h %h expected all 0",
               up_req_valid, up_req_addr, up_req_mdata);
    end
    check_drained("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int n = 0; n < N; n++) begin
      offset_array[n*64 +: 64] = 64'hFFFF_FC00_0000_0000 |
                                 (64'(n) << 12);
      drive(n, 42'h3FF_FFFF_F000 + 42'(n), 16'(n), 1'b1);
    end
    tick();
    afu_req_valid = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      checks++;
      if (up_req_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_consec cycle %0d valid=%b expected 1",
                 k, up_req_valid);
      end
    end
    tick();
    checks++;
    if (up_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_end valid=%b expected 0", up_req_valid);
    end
`ifdef VAI_TX_ARB_STATS_EN
    for (int n = 0; n < N; n++) begin
      checks++;
      if (grant_count[n*32 +: 32] !== 32'd1) begin
        errors++;
        $display("FAIL rr_gcnt%0d got %0d expected 1",
                 n, grant_count[n*32 +: 32]);
      end
    end
`endif
    check_drained("rr");
  endtask

  task automatic test_up_almfull();
    do_reset();
    up_almfull = 1'b1;
    drive(1, 42'h11, 16'h0101, 1'b1);
    drive(3, 42'h33, 16'h0303, 1'b1);
    drive(5, 42'h55, 16'h0505, 1'b1);
    tick();
    afu_req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (up_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL almfull_hold cycle %0d valid=%b expected 0",
                 k, up_req_valid);
      end
    end
    up_almfull = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (up_req_valid !== (k < 3)) begin
        errors++;
        $display("FAIL almfull_release cycle %0d valid=%b expected %b",
                 k, up_req_valid, k < 3);
      end
    end
    check_drained("almfull");
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    up_almfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 42'h300 + 42'(i), 16'(i), i < 4);
      tick();
      if (i == 0 || i == 1) begin
        checks++;
        if (afu_almfull[0] !== (i == 1)) begin
          errors++;
          $display("FAIL ovf_almfull push %0d got %b expected %b",
                   i + 1, afu_almfull[0], i == 1);
        end
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (overflow_err !== ((i == 4) ? 8'h01 : 8'h00)) begin
          errors++;
          $display("FAIL ovf_err push %0d got %h expected %h",
                   i + 1, overflow_err, (i == 4) ? 8'h01 : 8'h00);
        end
      end
    end
    afu_req_valid = '0;
    base = issue_cnt;
    up_almfull = 1'b0;
    repeat (8) tick();
    checks++;
    if (issue_cnt - base != 4) begin
      errors++;
      $display("FAIL ovf_issued got %0d expected 4", issue_cnt - base);
    end
    checks++;
    if (afu_almfull !== '0 || overflow_err !== 8'h01) begin
      errors++;
      $display("FAIL ovf_final almfull=%h ovf=%h expected 00 01",
               afu_almfull, overflow_err);
    end
    check_drained("ovf");
  endtask

  task automatic test_mdata_err();
    do_reset();
    drive(5, 42'h55, 16'hE001, 1'b1);
    tick();
    afu_req_valid = '0;
    checks++;
    if (mdata_err !== 8'h20) begin
      errors++;
      $display("FAIL merr_set got %h expected 20", mdata_err);
    end
    drive(5, 42'h56, 16'h0002, 1'b1);
    tick();
    afu_req_valid = '0;
    repeat (3) tick();
    checks++;
    if (mdata_err !== 8'h20 || overflow_err !== 8'h00) begin
      errors++;
      $display("FAIL merr_sticky merr=%h ovf=%h expected 20 00",
               mdata_err, overflow_err);
    end
    check_drained("merr");
  endtask

  task automatic test_pause();
    int  base;
    bit  got;
    do_reset();
    up_almfull = 1'b1;
    drive(0, 42'h40, 16'h0040, 1'b1);
    drive(2, 42'h42, 16'h0042, 1'b0);
    drive(4, 42'h44, 16'h0044, 1'b0);
    drive(6, 42'h46, 16'h0046, 1'b0);
    tick();
    afu_req_valid = '0;
    base = issue_cnt;
    up_almfull = 1'b0;
    tick();
    cfg_pause = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin
      tick();
      if (cfg_paused) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL pause_ack cfg_paused=%b expected 1 within 3",
               cfg_paused);
    end
    drive(1, 42'h41, 16'h0041, 1'b1);
    sb.push_back(model(2, 42'h42, 16'h0042));
    sb.push_back(model(4, 42'h44, 16'h0044));
    sb.push_back(model(6, 42'h46, 16'h0046));
    tick();
    afu_req_valid = '0;
    repeat (3) tick();
    checks++;
    if (issue_cnt - base != 1 || cfg_paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_quiet issued=%0d paused=%b expected 1 1",
               issue_cnt - base, cfg_paused);
    end
    cfg_pause = 1'b0;
    tick();
    checks++;
    if (cfg_paused !== 1'b0 || up_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume paused=%b valid=%b expected 0 0",
               cfg_paused, up_req_valid);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (up_req_valid !== (k < 4)) begin
        errors++;
        $display("FAIL pause_drain cycle %0d valid=%b expected %b",
                 k, up_req_valid, k < 4);
      end
    end
    check_drained("pause");
  endtask

  task automatic test_async_reset();
    int base;
    do_reset();
    for (int n = 0; n < N; n++)
      drive(n, 42'h500 + 42'(n), 16'hF000 | 16'(n), 1'b0);
    tick();
    afu_req_valid = '0;
    tick();
    checks++;
    if (up_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_burst valid=%b expected 1", up_req_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (up_req_valid !== 1'b0 || up_req_addr !== '0) begin
      errors++;
      $display("FAIL arst_immediate valid=%b addr=%h expected 0 0",
               up_req_valid, up_req_addr);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    base = issue_cnt;
    repeat (10) tick();
    checks++;
    if (issue_cnt != base) begin
      errors++;
      $display("FAIL arst_stale issued=%0d expected 0", issue_cnt - base);
    end
    checks++;
    if ({overflow_err, mdata_err, afu_almfull} !== '0) begin
      errors++;
      $display("FAIL arst_flags ovf=%h merr=%h almfull=%h expected 0",
               overflow_err, mdata_err, afu_almfull);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_up_almfull();
    test_overflow();
    test_mdata_err();
    test_pause();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
